mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  MEM-stage data-memory access controller; consumes EX/MEM register outputs (aluop, addr, store data, ALU result).
//  Issues one SRAM-like bus transaction per load/store, stalls the pipeline until data_ok, then merges load data into
//  the MEM-stage write-back value. Detects misaligned accesses (no bus request). Non-memory ops pass through, zero latency.
// PARAMETERS
//  TIMEOUT   255  max cycles in REQ+WAIT before abort; counter width = clog2(TIMEOUT+1)
// PORTS
//  clk            in   1   clock, all state on rising edge
//  resetn         in   1   asynchronous active-low reset
//  mem_aluop      in   8   op from EX/MEM; EXE_{LB,LBU,LH,LHU,LW,SB,SH,SW}_OP from define.v, others = non-memory
//  mem_mem_addr   in   32  effective address
//  mem_reg2       in   32  store data (rt)
//  mem_wdata      in   32  ALU result for non-load ops
//  flush          in   1   exception flush, same cycle EX/MEM sees it
//  pipe_hold      in   1   stall[4]: downstream (MEM/WB) not accepting this cycle
//  data_req       out  1   bus request
//  data_wr        out  1   1 = store
//  data_be        out  4   byte enables, bit i = byte lane i (little-endian)
//  data_addr      out  32  {mem_mem_addr[31:2],2'b00}
//  data_wdata     out  32  store data replicated to lanes (SB: {4{b}}, SH: {2{h}})
//  data_addr_ok   in   1   request accepted this cycle
//  data_rdata     in   32  read data, valid with data_ok
//  data_data_ok   in   1   transaction complete
//  result         out  32  value to MEM/WB (extended load data or mem_wdata)
//  stallreq_mem   out  1   hold stages 0..4
//  adel / ades    out  1   misaligned load / store address (combinational, held while op present)
//  bus_timeout    out  1   one-cycle pulse on TIMEOUT abort
// BEHAVIOUR
//  Reset: state=IDLE, data_req=0, data_wr=0, data_be=0, rdata_q=0, counter=0, bus_timeout=0; combinational outputs follow.
//  Misaligned: LH/LHU/SH addr[0]!=0; LW/SW addr[1:0]!=0 -> adel/ades=1, no request, stallreq_mem=0, result=mem_wdata.
//  States: IDLE, REQ, WAIT, DONE, DRAIN.
//   IDLE: aligned mem op && !flush -> REQ (request registered; data_req high from the next cycle).
//         stallreq_mem=1 in IDLE whenever a legal mem op is present. Non-mem op: stallreq_mem=0, result=mem_wdata.
//   REQ: data_req=1, addr/be/wdata/wr held stable. addr_ok -> WAIT (addr_ok&&data_ok same cycle -> DONE, capture rdata).
//        flush before addr_ok -> IDLE, data_req drops next cycle, nothing issued.
//   WAIT: data_req=0; data_ok -> DONE, capture data_rdata into rdata_q. flush -> DRAIN (data_ok in that cycle -> IDLE).
//   DONE: stallreq_mem=0; result from rdata_q (loads) or mem_wdata (stores). pipe_hold=1 -> stay DONE, no re-issue.
//         pipe_hold=0 or flush -> IDLE next cycle.
//   DRAIN: stallreq_mem=1; wait data_ok, discard data -> IDLE. Bus never cancelled after addr_ok.
//  Load extension (byte lane k=addr[1:0]): LB sign-ext rdata[8k+7:8k], LBU zero-ext; LH/LHU lane pair addr[1];
//   LW full word. BE: SB 4'b0001<<k, SH addr[1]?1100:0011, SW/LW 1111, LB/LH same as stores.
//  Timeout: counter clears on entering REQ, increments in REQ/WAIT; reaching TIMEOUT -> bus_timeout pulse, -> DONE,
//   result=0. Late data_ok after timeout ignored.
//  Reset mid-transaction: immediate IDLE, data_req=0; outstanding bus response ignored.
//  At most one outstanding transaction; next request only from IDLE.
// TESTING
//  LW 0x100, addr_ok c+1, data_ok c+3 rdata=0xDEADBEEF -> stallreq 4 cycles, DONE result=0xDEADBEEF, be=1111, one req.
//  LB addr 0x103 rdata=0x80FF_1234 -> result=0xFFFFFF80; LBU same -> 0x00000080; LHU 0x102 -> 0x000080FF.
//  SB addr 0x101 reg2=0x000000A5 -> data_wr=1, be=0010, wdata=0xA5A5A5A5; SH 0x101 -> ades=1, no data_req.
//  flush in WAIT, data_ok 2 cycles later -> DRAIN, stallreq held, result not written, next LW issues after drain.
//  DONE with pipe_hold=1 for 3 cycles -> exactly one bus transaction, result stable 0x12345678 throughout.
//  No data_ok for TIMEOUT cycles -> bus_timeout single pulse, stallreq drops, result=0; resetn low in REQ -> data_req=0 at once.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory access controller.
// Turns a load/store sitting in EX/MEM into a single SRAM-like bus
// transaction. The pipeline is stalled until the bus returns data_ok, and
// load data is then extended and merged into the write-back value.
// Misaligned accesses raise adel/ades and never reach the bus. Non-memory
// ops pass mem_wdata straight through with no added latency.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   mem_aluop            EX/MEM op code (load/store codes below, others non-mem)
//   mem_mem_addr         effective address
//   mem_reg2             store data (rt)
//   mem_wdata            ALU result used for non-load ops
//   flush                exception flush
//   pipe_hold            MEM/WB not accepting this cycle
//   data_req/wr/be/addr/wdata   bus request side (registered)
//   data_addr_ok/rdata/data_ok  bus response side
//   result               value handed to MEM/WB
//   stallreq_mem         stall request for stages 0..4
//   adel, ades           misaligned load / store address
//   bus_timeout          one-cycle pulse when a transaction is aborted
module mem_access_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_reg2,
  input  logic [31:0] mem_wdata,
  input  logic        flush,
  input  logic        pipe_hold,
  output logic        data_req,
  output logic        data_wr,
  output logic [3:0]  data_be,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic [31:0] data_rdata,
  input  logic        data_data_ok,
  output logic [31:0] result,
  output logic        stallreq_mem,
  output logic        adel,
  output logic        ades,
  output logic        bus_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [31:0]   rdata_q;
  logic          to_q;
  logic          abort, cap;

  // ---------------- op decode ----------------
  logic is_load, is_store, is_byte, is_half, is_word, sext, misal, legal;
  logic [1:0]  lane;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, ld_ext;

  assign lane = mem_mem_addr[1:0];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    sext     = 1'b0;
    unique case (mem_aluop)
      EXE_LB_OP:  begin is_load  = 1'b1; is_byte = 1'b1; sext = 1'b1; end
      EXE_LBU_OP: begin is_load  = 1'b1; is_byte = 1'b1; end
      EXE_LH_OP:  begin is_load  = 1'b1; is_half = 1'b1; sext = 1'b1; end
      EXE_LHU_OP: begin is_load  = 1'b1; is_half = 1'b1; end
      EXE_LW_OP:  begin is_load  = 1'b1; is_word = 1'b1; end
      EXE_SB_OP:  begin is_store = 1'b1; is_byte = 1'b1; end
      EXE_SH_OP:  begin is_store = 1'b1; is_half = 1'b1; end
      EXE_SW_OP:  begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
  end

  assign misal = (is_half && lane[0]) || (is_word && (lane != 2'b00));
  assign legal = (is_load || is_store) && !misal;
  assign adel  = is_load && misal;
  assign ades  = is_store && misal;

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = mem_reg2;
    if (is_byte) begin
      be_c    = 4'b0001 << lane;
      wdata_c = {4{mem_reg2[7:0]}};
    end else if (is_half) begin
      be_c    = lane[1] ? 4'b1100 : 4'b0011;
      wdata_c = {2{mem_reg2[15:0]}};
    end
  end

  // Load extension works off the captured word; the EX/MEM op and address
  // are still held because the pipeline was stalled until DONE.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    unique case (lane)
      2'd0:    b = rdata_q[7:0];
      2'd1:    b = rdata_q[15:8];
      2'd2:    b = rdata_q[23:16];
      default: b = rdata_q[31:24];
    endcase
    h = lane[1] ? rdata_q[31:16] : rdata_q[15:0];
    if (is_byte)      ld_ext = {{24{sext & b[7]}}, b};
    else if (is_half) ld_ext = {{16{sext & h[15]}}, h};
    else              ld_ext = rdata_q;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  // ---------------- FSM: next state ----------------
  // Once addr_ok has been seen the bus owns the transaction, so a flush
  // after that point drains the response instead of abandoning it.
  always_comb begin
    logic hit;
    hit     = (cnt == CW'(TIMEOUT - 1));
    state_n = state;
    abort   = 1'b0;
    cap     = 1'b0;
    unique case (state)
      IDLE: if (legal && !flush) state_n = REQ;
      REQ: begin
        if (flush && !data_addr_ok)       state_n = IDLE;
        else if (data_addr_ok && data_data_ok) begin
          state_n = flush ? IDLE : DONE;
          cap     = !flush;
        end
        else if (hit)                     begin state_n = DONE; abort = 1'b1; end
        else if (data_addr_ok)            state_n = flush ? DRAIN : WAIT;
      end
      WAIT: begin
        if (flush)             state_n = data_data_ok ? IDLE : DRAIN;
        else if (data_data_ok) begin state_n = DONE; cap = 1'b1; end
        else if (hit)          begin state_n = DONE; abort = 1'b1; end
      end
      DONE:  if (!pipe_hold || flush) state_n = IDLE;
      DRAIN: if (data_data_ok)        state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    stallreq_mem = 1'b1;
    result       = mem_wdata;
    unique case (state)
      IDLE: stallreq_mem = legal;
      DONE: begin
        stallreq_mem = 1'b0;
        if (to_q)         result = '0;
        else if (is_load) result = ld_ext;
      end
      default: ;
    endcase
  end

  // ---------------- bus request, capture, timeout ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_req    <= 1'b0;
      data_wr     <= 1'b0;
      data_be     <= '0;
      data_addr   <= '0;
      data_wdata  <= '0;
      rdata_q     <= '0;
      cnt         <= '0;
      to_q        <= 1'b0;
      bus_timeout <= 1'b0;
    end else begin
      data_req    <= (state_n == REQ);
      bus_timeout <= abort;
      if (state == IDLE && state_n == REQ) begin
        data_wr    <= is_store;
        data_be    <= be_c;
        data_addr  <= {mem_mem_addr[31:2], 2'b00};
        data_wdata <= wdata_c;
        cnt        <= '0;
        to_q       <= 1'b0;
      end else if (state == REQ || state == WAIT) begin
        cnt <= cnt + 1'b1;
      end
      if (abort) to_q    <= 1'b1;
      if (cap)   rdata_q <= data_rdata;
    end
  end

endmodule
